// File: rtl/axi_lite_dma_csr_slave.sv
// AXI4-Lite control/status register block for one DMA channel (CR, SR, SA, LENGTH).
// Optional IOC interrupt path is compiled in with `define DMA_CSR_IRQ_EN.
module axi_lite_dma_csr_slave #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [31:0]       s_axi_lite_wdata,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic [ADDR_W-1:0] s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [31:0]       s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready,
  output logic              run,
  output logic              start,
  output logic [31:0]       src_addr,
  output logic [LEN_W-1:0]  length,
  input  logic              engine_busy,
  input  logic              engine_done,
  output logic              irq
);

  localparam logic [7:0] A_CR  = 8'h00;
  localparam logic [7:0] A_SR  = 8'h04;
  localparam logic [7:0] A_SA  = 8'h18;
  localparam logic [7:0] A_LEN = 8'h28;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic addr_mapped(input logic [7:0] a);
    return (a == A_CR) || (a == A_SR) || (a == A_SA) || (a == A_LEN);
  endfunction

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;
  logic w_aw_acc, w_ar_acc;

  logic [7:0] w_waddr, w_raddr;
  logic w_wr_cr, w_wr_sr, w_wr_sa, w_wr_len, w_soft_rst, w_start_req;
  logic w_halted, w_idle, w_irqen_bit, w_ioc_bit, w_unused_irq;

  logic             r_rs, r_pend, r_start;
  logic [31:0]      r_sa;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_bresp;
  logic [31:0]      r_rdata, w_rdata_mux;
  logic [1:0]       r_rresp, w_rresp_mux;

  // Write channel: state register
  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  // Write channel: next state; address and data are only taken together
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) w_wstate_nxt = W_RESP;
        else                                          w_wstate_nxt = W_IDLE;
      end
      W_RESP: begin
        if (s_axi_lite_bready) w_wstate_nxt = W_IDLE;
        else                   w_wstate_nxt = W_RESP;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel: outputs
  always_comb begin
    w_aw_acc = 1'b0;
    case (r_wstate)
      W_IDLE:  w_aw_acc = s_axi_lite_awvalid && s_axi_lite_wvalid;
      W_RESP:  w_aw_acc = 1'b0;
      default: w_aw_acc = 1'b0;
    endcase
  end

  // Read channel: state register
  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  // Read channel: next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (s_axi_lite_arvalid) w_rstate_nxt = R_DATA;
        else                    w_rstate_nxt = R_IDLE;
      end
      R_DATA: begin
        if (s_axi_lite_rready) w_rstate_nxt = R_IDLE;
        else                   w_rstate_nxt = R_DATA;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read channel: outputs
  always_comb begin
    w_ar_acc = 1'b0;
    case (r_rstate)
      R_IDLE:  w_ar_acc = s_axi_lite_arvalid;
      R_DATA:  w_ar_acc = 1'b0;
      default: w_ar_acc = 1'b0;
    endcase
  end

  assign w_waddr    = s_axi_lite_awaddr[7:0];
  assign w_raddr    = s_axi_lite_araddr[7:0];
  assign w_wr_cr    = w_aw_acc && (w_waddr == A_CR);
  assign w_wr_sr    = w_aw_acc && (w_waddr == A_SR);
  assign w_wr_sa    = w_aw_acc && (w_waddr == A_SA);
  assign w_wr_len   = w_aw_acc && (w_waddr == A_LEN);
  assign w_soft_rst = w_wr_cr && s_axi_lite_wdata[2];
  assign w_start_req = w_wr_len && r_rs;

  // Write response code, latched on acceptance
  always_ff @(posedge clk) begin
    if (rst)           r_bresp <= RESP_OKAY;
    else if (w_aw_acc) r_bresp <= addr_mapped(w_waddr) ? RESP_OKAY : RESP_DECERR;
    else               r_bresp <= r_bresp;
  end

  // CR.RS
  always_ff @(posedge clk) begin
    if (rst || w_soft_rst) r_rs <= 1'b0;
    else if (w_wr_cr)      r_rs <= s_axi_lite_wdata[0];
    else                   r_rs <= r_rs;
  end

  // SA and LENGTH
  always_ff @(posedge clk) begin
    if (rst || w_soft_rst) begin
      r_sa  <= 32'h0000_0000;
      r_len <= {LEN_W{1'b0}};
    end else begin
      if (w_wr_sa)  r_sa  <= s_axi_lite_wdata;
      else          r_sa  <= r_sa;
      if (w_wr_len) r_len <= s_axi_lite_wdata[LEN_W-1:0];
      else          r_len <= r_len;
    end
  end

  // Start pulse and pending flag; pend bridges the gap until the engine reports busy
  always_ff @(posedge clk) begin
    if (rst) r_start <= 1'b0;
    else     r_start <= w_start_req;
  end

  // Pending start tracking
  always_ff @(posedge clk) begin
    if (rst || w_soft_rst) r_pend <= 1'b0;
    else if (w_start_req)  r_pend <= 1'b1;
    else if (engine_busy || !r_rs || (w_wr_cr && !s_axi_lite_wdata[0])) r_pend <= 1'b0;
    else                   r_pend <= r_pend;
  end

`ifdef DMA_CSR_IRQ_EN
  logic r_ioc_irqen, r_ioc_irq, r_irq;

  // IOC interrupt enable
  always_ff @(posedge clk) begin
    if (rst || w_soft_rst) r_ioc_irqen <= 1'b0;
    else if (w_wr_cr)      r_ioc_irqen <= s_axi_lite_wdata[12];
    else                   r_ioc_irqen <= r_ioc_irqen;
  end

  // IOC status: engine_done set takes priority over a coincident W1C
  always_ff @(posedge clk) begin
    if (rst || w_soft_rst)                      r_ioc_irq <= 1'b0;
    else if (engine_done)                       r_ioc_irq <= 1'b1;
    else if (w_wr_sr && s_axi_lite_wdata[12])   r_ioc_irq <= 1'b0;
    else                                        r_ioc_irq <= r_ioc_irq;
  end

  // Registered interrupt line
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_ioc_irq && r_ioc_irqen;
  end

  assign w_irqen_bit  = r_ioc_irqen;
  assign w_ioc_bit    = r_ioc_irq;
  assign w_unused_irq = 1'b0;
  assign irq          = r_irq;
`else
  assign w_irqen_bit  = 1'b0;
  assign w_ioc_bit    = 1'b0;
  assign w_unused_irq = engine_done ^ w_wr_sr;
  assign irq          = 1'b0;
`endif

  assign w_halted = ~r_rs;
  assign w_idle   = r_rs && !engine_busy && !r_pend;

  // Read data mux over current register state
  always_comb begin
    w_rdata_mux = 32'h0000_0000;
    w_rresp_mux = RESP_OKAY;
    case (w_raddr)
      A_CR:  w_rdata_mux = {19'b0, w_irqen_bit, 11'b0, r_rs};
      A_SR:  w_rdata_mux = {19'b0, w_ioc_bit, 10'b0, w_idle, w_halted};
      A_SA:  w_rdata_mux = r_sa;
      A_LEN: w_rdata_mux = {{(32-LEN_W){1'b0}}, r_len};
      default: begin
        w_rdata_mux = 32'h0000_0000;
        w_rresp_mux = RESP_DECERR;
      end
    endcase
  end

  // Read data capture; held until the master takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_acc) begin
      r_rdata <= w_rdata_mux;
      r_rresp <= w_rresp_mux;
    end else begin
      r_rdata <= r_rdata;
      r_rresp <= r_rresp;
    end
  end

  logic w_unused;
  assign w_unused = ^{s_axi_lite_awaddr[ADDR_W-1:8], s_axi_lite_araddr[ADDR_W-1:8], w_unused_irq};

  assign s_axi_lite_awready = w_aw_acc;
  assign s_axi_lite_wready  = w_aw_acc;
  assign s_axi_lite_bvalid  = (r_wstate == W_RESP);
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = w_ar_acc;
  assign s_axi_lite_rvalid  = (r_rstate == R_DATA);
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;
  assign run      = r_rs;
  assign start    = r_start;
  assign src_addr = r_sa;
  assign length   = r_len;

endmodule

// File: tb/tb_axi_lite_dma_csr_slave.sv
// Directed self-checking bench for axi_lite_dma_csr_slave (IRQ expectations follow DMA_CSR_IRQ_EN).
module tb_axi_lite_dma_csr_slave;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 26;
`ifdef DMA_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] A_CR  = 10'h000;
  localparam logic [ADDR_W-1:0] A_SR  = 10'h004;
  localparam logic [ADDR_W-1:0] A_SA  = 10'h018;
  localparam logic [ADDR_W-1:0] A_LEN = 10'h028;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, src_addr;
  logic [1:0] bresp, rresp;
  logic run, start, engine_busy, engine_done, irq;
  logic [LEN_W-1:0] length;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;

  axi_lite_dma_csr_slave #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready),
    .run(run), .start(start), .src_addr(src_addr), .length(length),
    .engine_busy(engine_busy), .engine_done(engine_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // count cycles in which start was high
  always @(posedge clk) if (start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input bit done_at_hs, output logic [1:0] resp);
    bit hs = 1'b0;
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!hs && n < 20) begin
      #1;
      hs = awready && wready;
      if (hs && done_at_hs) engine_done = 1'b1;
      @(negedge clk);
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; engine_done = 1'b0;
    if (!hs) check("write_accept_timeout", 32'(hs), 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) check("bvalid_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
    bit hs = 1'b0;
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = (hold == 0);
    while (!hs && n < 20) begin
      #1;
      hs = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    if (!hs) check("read_accept_timeout", 32'(hs), 32'd1);
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) check("rvalid_timeout", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_held", 32'(rvalid), 32'd1);
      check("rdata_stable", rdata, d);
    end
    rready = 1'b1;
    @(negedge clk);
    if (hold > 0) check("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0] r, r2;
    int sc;
    awaddr = '0; araddr = '0; wdata = 32'h0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
    engine_busy = 1'b0; engine_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_sa", src_addr, 32'h0);
    check("rst_len", 32'(length), 32'h0);

    axi_read(A_SR, 5, d, r);
    check("sr_after_reset", d, 32'h0000_0001);
    check("sr_after_reset_resp", 32'(r), 32'd0);

    axi_write(A_CR, 32'h1, 1'b0, r);
    check("cr_bresp", 32'(r), 32'd0);
    check("run_set", 32'(run), 32'd1);
    axi_read(A_SR, 0, d, r);
    check("sr_idle", d, 32'h0000_0002);

    axi_write(A_SA, 32'h8000_0000, 1'b0, r);
    check("sa_out", src_addr, 32'h8000_0000);
    sc = start_cnt;
    axi_write(A_LEN, 32'h100, 1'b0, r);
    check("start_one_cycle", 32'(start_cnt - sc), 32'd1);
    check("len_out", 32'(length), 32'h100);
    axi_read(A_SR, 0, d, r);
    check("sr_pend", d, 32'h0);
    engine_busy = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(A_SR, 0, d, r);
    check("sr_busy", d, 32'h0);
    engine_busy = 1'b0;
    @(negedge clk);
    axi_read(A_SR, 0, d, r);
    check("sr_done_idle", d, 32'h2);
    axi_read(A_LEN, 0, d, r);
    check("len_read", d, 32'h100);

    axi_write(A_CR, 32'h1001, 1'b0, r);
    axi_read(A_CR, 0, d, r);
    check("cr_irqen", d, IRQ_ON ? 32'h1001 : 32'h1);
    engine_done = 1'b1;
    @(negedge clk);
    engine_done = 1'b0;
    @(negedge clk);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    axi_read(A_SR, 0, d, r);
    check("sr_ioc", d, IRQ_ON ? 32'h1002 : 32'h2);
    axi_write(A_SR, 32'h1000, 1'b0, r);
    check("irq_cleared", 32'(irq), 32'd0);
    axi_read(A_SR, 0, d, r);
    check("sr_w1c", d, 32'h2);
    engine_done = 1'b1;
    @(negedge clk);
    engine_done = 1'b0;
    axi_write(A_SR, 32'h1000, 1'b1, r);
    axi_read(A_SR, 0, d, r);
    check("sr_set_wins", d, IRQ_ON ? 32'h1002 : 32'h2);
    axi_write(A_SR, 32'h1000, 1'b0, r);

    awaddr = A_SA; wdata = 32'h1111_2222; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("aw_only_awready", 32'(awready), 32'd0);
      check("aw_only_wready", 32'(wready), 32'd0);
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    check("aw_w_awready", 32'(awready), 32'd1);
    check("aw_w_wready", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_up", 32'(bvalid), 32'd1);
    check("sa_first", src_addr, 32'h1111_2222);
    wdata = 32'h3333_4444; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("no_accept_in_resp", 32'(awready), 32'd0);
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
    end
    check("sa_not_overwritten", src_addr, 32'h1111_2222);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("bvalid_drop", 32'(bvalid), 32'd0);

    axi_read(10'h03C, 0, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", 32'(r), 32'd3);
    axi_write(10'h03C, 32'hFFFF_FFFF, 1'b0, r);
    check("unmapped_bresp", 32'(r), 32'd3);
    check("unmapped_run", 32'(run), 32'd1);
    check("unmapped_sa", src_addr, 32'h1111_2222);
    check("unmapped_len", 32'(length), 32'h100);
    axi_read(A_CR, 0, d, r);
    check("unmapped_cr", d, IRQ_ON ? 32'h1001 : 32'h1);
    axi_read(10'h304, 0, d, r);
    check("upper_addr_ignored", d, 32'h2);

    fork
      axi_write(A_SA, 32'hA5A5_0000, 1'b0, r);
      axi_read(A_SA, 0, d2, r2);
    join
    check("same_edge_old_value", d2, 32'h1111_2222);
    check("same_edge_new_sa", src_addr, 32'hA5A5_0000);

    axi_write(A_CR, 32'h4, 1'b0, r);
    check("softrst_bresp", 32'(r), 32'd0);
    check("softrst_run", 32'(run), 32'd0);
    axi_read(A_SR, 0, d, r);
    check("softrst_sr", d, 32'h1);
    axi_read(A_SA, 0, d, r);
    check("softrst_sa", d, 32'h0);
    axi_read(A_LEN, 0, d, r);
    check("softrst_len", d, 32'h0);
    axi_read(A_CR, 0, d, r);
    check("softrst_cr", d, 32'h0);

    sc = start_cnt;
    axi_write(A_LEN, 32'hFFFF_FFFF, 1'b0, r);
    check("len_rs0_no_start", 32'(start_cnt - sc), 32'd0);
    axi_read(A_LEN, 0, d, r);
    check("len_truncated", d, 32'h03FF_FFFF);

    axi_write(A_CR, 32'h1, 1'b0, r);
    axi_write(A_LEN, 32'h40, 1'b0, r);
    axi_write(A_CR, 32'h0, 1'b0, r);
    check("rs_drop_run", 32'(run), 32'd0);
    axi_read(A_SR, 0, d, r);
    check("rs_drop_sr", d, 32'h1);
    axi_write(A_CR, 32'h1, 1'b0, r);
    axi_read(A_SR, 0, d, r);
    check("rs_drop_pend_cleared", d, 32'h2);

    araddr = A_SR; arvalid = 1'b1; rready = 1'b0;
    awaddr = A_SA; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    check("pre_rst_bvalid", 32'(bvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_run", 32'(run), 32'd0);
    rst = 1'b0; rready = 1'b1; bready = 1'b1;
    axi_read(A_SR, 0, d, r);
    check("post_rst_sr", d, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_dma_csr_slave.md
Name: axi_lite_dma_csr_slave

Overview:
- AXI4-Lite responder holding the control/status registers (CSR) of a simple DMA channel.
- Sits between the accelerator's AXI-Lite control master and the DMA datapath engine.
- Answers status polls at offset 0x04 with halted/idle bits.
- Turns CR/SA/LENGTH writes into run and start controls for the engine.

Parameters:
- ADDR_W, 10, AXI-Lite address width; only bits [7:0] decoded, upper bits ignored.
- LEN_W, 26, width of the LENGTH register (bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axi_lite_awaddr  in  ADDR_W  write address
- s_axi_lite_awvalid  in  1  write address valid
- s_axi_lite_awready  out  1  write address ready
- s_axi_lite_wdata  in  32  write data
- s_axi_lite_wvalid  in  1  write data valid
- s_axi_lite_wready  out  1  write data ready
- s_axi_lite_bresp  out  2  write response
- s_axi_lite_bvalid  out  1  write response valid
- s_axi_lite_bready  in  1  write response ready
- s_axi_lite_araddr  in  ADDR_W  read address
- s_axi_lite_arvalid  in  1  read address valid
- s_axi_lite_arready  out  1  read address ready
- s_axi_lite_rdata  out  32  read data
- s_axi_lite_rresp  out  2  read response
- s_axi_lite_rvalid  out  1  read data valid
- s_axi_lite_rready  in  1  read data ready
- run  out  1  CR.RS level to the engine
- start  out  1  one-cycle transfer start pulse
- src_addr  out  32  SA register
- length  out  LEN_W  LENGTH register
- engine_busy  in  1  engine transfer in progress
- engine_done  in  1  one-cycle pulse at transfer completion
- irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high; clk rising edge. All outputs, registers and channel state go to 0. SR.halted reads 1 after reset.
- Register map:
  - 0x00 CR: bit0 RS (R/W); bit2 SOFT_RST (W, reads 0); bit12 IOC_IRQEN (R/W).
  - 0x04 SR (RO except bit12):
    - bit0 HALTED = ~RS.
    - bit1 IDLE = RS & ~engine_busy & ~pend.
    - bit12 IOC_IRQ, W1C.
  - 0x18 SA: R/W, 32 bits.
  - 0x28 LENGTH: R/W, LEN_W bits, zero-extended on read.
- Write channel FSM (W_IDLE, W_RESP):
  - In W_IDLE, awready=wready=1 for exactly one cycle when awvalid & wvalid are both high. Register update happens on that edge.
  - Next cycle: bvalid=1, state W_RESP. bvalid is held until bready, then back to W_IDLE.
  - Address-only or data-only presentation is not accepted; wait for both.
  - No acceptance while bvalid=1.
- Read channel FSM (R_IDLE, R_DATA):
  - In R_IDLE with arvalid, arready=1 for one cycle; rdata is captured on the same edge.
  - Next cycle rvalid=1; rdata/rresp are held stable until rready, then back to R_IDLE.
- Responses: mapped address gives OKAY 2'b00. Unmapped gives DECERR 2'b11, with reads returning 0 and writes having no effect.
- Channel independence: read and write channels run independently. A read and write accepted on the same edge return the pre-write value.
- Start generation: a LENGTH write with RS=1 (current or written same cycle impossible; CR/LENGTH are separate accesses) sets start=1 for exactly the next cycle and sets pend.
  - pend clears when engine_busy is first seen high.
  - LENGTH write with RS=0 updates LENGTH only, no start.
- IOC_IRQ:
  - Set by engine_done.
  - Cleared by writing 1 to SR bit12.
  - Simultaneous set and clear: set wins.
- SOFT_RST: a CR write with bit2=1 clears RS, SA, LENGTH, IOC_IRQ, IOC_IRQEN and pend.
  - The write still completes with bvalid/OKAY.
  - Read/write channel FSMs are not affected.
- RS 1->0: run drops next cycle and pend clears. The engine finishes on its own; IDLE reports 0 while RS=0.

Optional Feature:
- Macro DMA_CSR_IRQ_EN.
- Defined: irq = IOC_IRQ & IOC_IRQEN, registered (1-cycle latency after the enabling event).
- Undefined: irq tied 0; CR bit12 and SR bit12 are not stored and read 0; W1C writes are ignored.

Test Plan:
- Reset, read 0x04 -> rdata=0x00000001, rresp=00; rvalid held while rready=0 for 5 cycles with stable rdata.
- Write CR=0x1, engine_busy=0, read SR -> 0x00000002; write SA=0x8000_0000, LENGTH=0x100 -> start high exactly 1 cycle, length=0x100, SR bit1=0 until busy rises and falls.
- Write CR=0x1001 (build with DMA_CSR_IRQ_EN), pulse engine_done -> SR=0x1002, irq=1; write SR=0x1000 -> irq=0; W1C coincident with engine_done -> bit12 stays 1.
- Write awvalid held 3 cycles before wvalid -> awready/wready both pulse only in the cycle wvalid arrives; bready held low -> no second write accepted.
- Read 0x3C and write 0x3C -> resp=11, rdata=0, no register changes; CR write 0x4 -> SR=0x1, SA=LENGTH=0, bresp=00.
- Assert rst while rvalid=1 and bvalid=1 -> both 0 next cycle, run=0, SR reads 0x1.
